// File: rtl/uart_rx_core_if.sv
// Holding-register side of the UART receiver: received byte, its status flags and the consumer's ack.
// valid/ack: rx_valid is a level while the register is full; one cycle of rx_ack with rx_valid=1 pops it.
interface uart_rx_core_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_fe;
    logic       rx_pe;
    logic       rx_ovr;
    logic       rx_ack;

    modport master (
        output rx_data,
        output rx_valid,
        output rx_fe,
        output rx_pe,
        output rx_ovr,
        input  rx_ack
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        input  rx_fe,
        input  rx_pe,
        input  rx_ovr,
        output rx_ack
    );
endinterface

// File: rtl/uart_rx_core.sv
// UART receive engine: 8 data bits LSB first, optional parity, one stop bit, one-entry holding register.
// Frame sampling is timed from the start-edge detection using the divider latched at that moment.
module uart_rx_core #(
    parameter int DIV_W  = 16,
    parameter int SYNC_N = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [DIV_W-1:0] baud_div,
    input  logic             par_en,
    input  logic             par_odd,
    input  logic             rx,
    output logic             busy,
    output logic [2:0]       dbg_state,
    uart_rx_core_if.master   hold
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    localparam logic [DIV_W-1:0] ONE = {{(DIV_W-1){1'b0}}, 1'b1};

    state_t           state, state_n;
    logic [SYNC_N-1:0] sync_q;
    logic             rxs, rxs_d;
    logic [DIV_W-1:0] cnt, div_q, half_q;
    logic             par_en_q, par_odd_q;
    logic [2:0]       bit_cnt;
    logic [7:0]       shreg;
    logic             pe_tmp, fe_tmp, cmpl;
    logic             tick_start, tick_bit, start_det, load;

    assign rxs        = sync_q[SYNC_N-1];
    assign tick_start = (cnt == half_q - ONE);
    assign tick_bit   = (cnt == div_q - ONE);
    assign start_det  = en && rxs_d && !rxs;
    assign busy       = (state != IDLE);
    assign dbg_state  = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '1;
            rxs_d  <= 1'b1;
        end else begin
            sync_q <= {sync_q[SYNC_N-2:0], rx};
            rxs_d  <= rxs;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (start_det) state_n = START;
            START:   if (tick_start) state_n = rxs ? IDLE : DATA;
            DATA:    if (tick_bit && bit_cnt == 3'd7) state_n = par_en_q ? PARITY : STOP;
            PARITY:  if (tick_bit) state_n = STOP;
            STOP:    if (tick_bit) state_n = IDLE;
            default: state_n = IDLE;
        endcase
        if (!en) state_n = IDLE;
    end

    // Bit timing and deserialisation; every run of cnt restarts at 0 on each sample point.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= '0;
            div_q     <= '0;
            half_q    <= '0;
            par_en_q  <= 1'b0;
            par_odd_q <= 1'b0;
            bit_cnt   <= '0;
            shreg     <= '0;
            pe_tmp    <= 1'b0;
            fe_tmp    <= 1'b0;
            cmpl      <= 1'b0;
        end else begin
            cmpl <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_det) begin
                        cnt       <= '0;
                        div_q     <= baud_div;
                        half_q    <= baud_div >> 1;
                        par_en_q  <= par_en;
                        par_odd_q <= par_odd;
                        bit_cnt   <= '0;
                        pe_tmp    <= 1'b0;
                    end
                end
                START: cnt <= tick_start ? '0 : cnt + ONE;
                DATA: begin
                    if (tick_bit) begin
                        cnt     <= '0;
                        shreg   <= {rxs, shreg[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                    end else begin
                        cnt <= cnt + ONE;
                    end
                end
                PARITY: begin
                    if (tick_bit) begin
                        cnt    <= '0;
                        pe_tmp <= ((^shreg) ^ rxs) != par_odd_q;
                    end else begin
                        cnt <= cnt + ONE;
                    end
                end
                STOP: begin
                    if (tick_bit) begin
                        cnt    <= '0;
                        fe_tmp <= ~rxs;
                        cmpl   <= en;
                    end else begin
                        cnt <= cnt + ONE;
                    end
                end
                default: cnt <= '0;
            endcase
        end
    end

    // Holding register: a completed frame loads if empty or being popped this cycle, otherwise it is dropped.
    assign load = cmpl && (!hold.rx_valid || hold.rx_ack);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold.rx_data  <= 8'h00;
            hold.rx_valid <= 1'b0;
            hold.rx_fe    <= 1'b0;
            hold.rx_pe    <= 1'b0;
            hold.rx_ovr   <= 1'b0;
        end else begin
            if (load) begin
                hold.rx_data  <= shreg;
                hold.rx_fe    <= fe_tmp;
                hold.rx_pe    <= pe_tmp;
                hold.rx_valid <= 1'b1;
                if (hold.rx_ack) hold.rx_ovr <= 1'b0;
            end else if (cmpl) begin
                hold.rx_ovr <= 1'b1;
            end else if (hold.rx_ack && hold.rx_valid) begin
                hold.rx_valid <= 1'b0;
                hold.rx_ovr   <= 1'b0;
            end
        end
    end

endmodule
